// File: rtl/rep_tx_pkg.sv
// Shared types and sizing helpers for the repetition-code serial transmitter.
package rep_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rep_serial_tx_if.sv
// Word-input handshake plus serial symbol outputs of rep_serial_tx.
interface rep_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_stb;
  logic              tx_sof;
  logic              tx_eof;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_bit, tx_stb, tx_sof, tx_eof, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_bit, tx_stb, tx_sof, tx_eof, busy
  );
endinterface

// File: rtl/rep_sym_timer.sv
// Nested symbol timer: cycles within a symbol slot, then repetitions of one bit.
module rep_sym_timer
  import rep_tx_pkg::*;
#(
  parameter int REP        = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic sym_start,
  output logic rep_first,
  output logic rep_last,
  output logic cyc_last
);
  localparam int CW = cnt_w(BIT_CYCLES);
  localparam int RW = cnt_w(REP);
  localparam logic [CW-1:0] CYC_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP - 1);

  logic [CW-1:0] cyc_cnt;
  logic [RW-1:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cyc_cnt <= '0;
      rep_cnt <= '0;
    end else if (enable) begin
      if (cyc_last) begin
        cyc_cnt <= '0;
        rep_cnt <= rep_last ? '0 : rep_cnt + RW'(1);
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
    end
  end

  assign sym_start = (cyc_cnt == '0);
  assign cyc_last  = (cyc_cnt == CYC_MAX);
  assign rep_first = (rep_cnt == '0);
  assign rep_last  = (rep_cnt == REP_MAX);

endmodule

// File: rtl/rep_serial_tx.sv
// Repetition-code serial transmitter: each word bit, LSB first, sent REP times
// in consecutive symbol slots of BIT_CYCLES clocks each.
module rep_serial_tx
  import rep_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REP        = 3,
  parameter int BIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  rep_serial_tx_if.slave bus
);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [BW-1:0]       bit_idx;
  logic                sending;
  logic                accept;
  logic                bit_last;
  logic                sym_start;
  logic                rep_first;
  logic                rep_last;
  logic                cyc_last;

  assign sending  = (state == ST_SEND);
  assign accept   = !sending && bus.in_valid;
  assign bit_last = (bit_idx == BIT_MAX);

  rep_sym_timer #(
    .REP        (REP),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .enable    (sending),
    .sym_start (sym_start),
    .rep_first (rep_first),
    .rep_last  (rep_last),
    .cyc_last  (cyc_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state   <= ST_SEND;
            bit_idx <= '0;
            shreg   <= bus.in_data;
          end
        end
        ST_SEND: begin
          // A bit is finished once its last repetition's last cycle passes.
          if (cyc_last && rep_last) begin
            if (bit_last) begin
              state <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              shreg   <= shreg >> 1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = !sending;
  assign bus.busy     = sending;
  assign bus.tx_bit   = sending && shreg[0];
  assign bus.tx_stb   = sending && sym_start;
  assign bus.tx_sof   = sending && sym_start && rep_first && (bit_idx == '0);
  assign bus.tx_eof   = sending && sym_start && rep_last && bit_last;

endmodule

// File: tb/tb_rep_serial_tx.sv
// Bench for rep_serial_tx across four parameter sets, with a per-cycle
// frame model and a majority-vote receiver model for the loopback pass.
module tb_rep_serial_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  int         checks = 0;
  int         errors = 0;

  int cfg_dw  [4] = '{4, 4, 1, 8};
  int cfg_rep [4] = '{3, 3, 1, 3};
  int cfg_bc  [4] = '{1, 2, 1, 1};

  always #5 clk = ~clk;

  rep_serial_tx_if #(.DATA_W(4)) a_if ();
  rep_serial_tx_if #(.DATA_W(4)) b_if ();
  rep_serial_tx_if #(.DATA_W(1)) c_if ();
  rep_serial_tx_if #(.DATA_W(8)) d_if ();

  assign a_if.in_data  = din[3:0];
  assign b_if.in_data  = din[3:0];
  assign c_if.in_data  = din[0:0];
  assign d_if.in_data  = din;
  assign a_if.in_valid = valid && (sel == 2'd0);
  assign b_if.in_valid = valid && (sel == 2'd1);
  assign c_if.in_valid = valid && (sel == 2'd2);
  assign d_if.in_valid = valid && (sel == 2'd3);

  rep_serial_tx #(.DATA_W(4), .REP(3), .BIT_CYCLES(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  rep_serial_tx #(.DATA_W(4), .REP(3), .BIT_CYCLES(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  rep_serial_tx #(.DATA_W(1), .REP(1), .BIT_CYCLES(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  rep_serial_tx #(.DATA_W(8), .REP(3), .BIT_CYCLES(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(d_if.slave));

  logic obs_ready, obs_busy, obs_bit, obs_stb, obs_sof, obs_eof;

  always_comb begin
    obs_ready = a_if.in_ready; obs_busy = a_if.busy; obs_bit = a_if.tx_bit;
    obs_stb = a_if.tx_stb; obs_sof = a_if.tx_sof; obs_eof = a_if.tx_eof;
    case (sel)
      2'd1: begin
        obs_ready = b_if.in_ready; obs_busy = b_if.busy; obs_bit = b_if.tx_bit;
        obs_stb = b_if.tx_stb; obs_sof = b_if.tx_sof; obs_eof = b_if.tx_eof;
      end
      2'd2: begin
        obs_ready = c_if.in_ready; obs_busy = c_if.busy; obs_bit = c_if.tx_bit;
        obs_stb = c_if.tx_stb; obs_sof = c_if.tx_sof; obs_eof = c_if.tx_eof;
      end
      2'd3: begin
        obs_ready = d_if.in_ready; obs_busy = d_if.busy; obs_bit = d_if.tx_bit;
        obs_stb = d_if.tx_stb; obs_sof = d_if.tx_sof; obs_eof = d_if.tx_eof;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cfg %0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    check({tag, "_busy"},  32'(obs_busy),  32'd0);
    check({tag, "_bit"},   32'(obs_bit),   32'd0);
    check({tag, "_stb"},   32'(obs_stb),   32'd0);
    check({tag, "_sof"},   32'(obs_sof),   32'd0);
    check({tag, "_eof"},   32'(obs_eof),   32'd0);
  endtask

  // Starts in a cycle where the selected DUT is idle; accepts word at this
  // cycle's edge, checks all L frame cycles, and returns in cycle L+1.
  task automatic frame(input logic [7:0] word, input logic hold, input logic [7:0] nxt,
                       input logic loopback);
    int dw, rep, bc, len, sym, b, f, ones;
    logic [7:0] wm, rec;
    logic exp_stb;
    logic syms [24];
    dw = cfg_dw[sel]; rep = cfg_rep[sel]; bc = cfg_bc[sel];
    len = dw * rep * bc;
    wm = word & 8'((16'h1 << dw) - 16'h1);
    rec = 8'h00;
    for (int i = 0; i < 24; i++) syms[i] = 1'b0;
    din = word; valid = 1'b1;
    check("accept_ready", 32'(obs_ready), 32'd1);
    @(posedge clk); #1;
    for (int k = 1; k <= len; k++) begin
      if (hold) begin
        din = nxt; valid = 1'b1;
      end else begin
        din = 8'($urandom); valid = 1'($urandom_range(0, 1));
      end
      sym = (k - 1) / bc;
      b = sym / rep;
      exp_stb = ((k - 1) % bc) == 0;
      check("tx_bit",   32'(obs_bit),   32'(wm[b]));
      check("tx_stb",   32'(obs_stb),   32'(exp_stb));
      check("tx_sof",   32'(obs_sof),   32'(exp_stb && sym == 0));
      check("tx_eof",   32'(obs_eof),   32'(exp_stb && sym == dw * rep - 1));
      check("busy",     32'(obs_busy),  32'd1);
      check("in_ready", 32'(obs_ready), 32'd0);
      if (exp_stb) syms[sym] = obs_bit;
      @(posedge clk); #1;
    end
    valid = hold; din = nxt;
    check_idle("post_frame");
    if (loopback) begin
      for (int bi = 0; bi < dw; bi++) begin
        f = $urandom_range(0, rep - 1);
        ones = 0;
        for (int r = 0; r < rep; r++) ones += int'(syms[bi * rep + r] ^ (r == f));
        rec[bi] = (ones * 2 > rep);
      end
      check("loopback_word", 32'(rec), 32'(wm));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      check_idle("reset");
    end
    sel = 2'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(8'h0B, 1'b0, 8'h00, 1'b0);
    frame(8'h0A, 1'b1, 8'h05, 1'b0);
    frame(8'h05, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;

    // Reset in cycle 5 of a frame, with in_valid high across the reset edge.
    din = 8'h0F; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check("pre_reset_busy", 32'(obs_busy), 32'd1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; valid = 1'b1; din = 8'h0A;
    @(posedge clk); #1;
    check_idle("mid_reset");
    rst_n = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    check_idle("after_reset");
    frame(8'h06, 1'b0, 8'h00, 1'b0);

    sel = 2'd1; valid = 1'b0;
    @(posedge clk); #1;
    frame(8'h01, 1'b0, 8'h00, 1'b0);
    frame(8'($urandom), 1'b0, 8'h00, 1'b0);

    sel = 2'd2; valid = 1'b0;
    @(posedge clk); #1;
    frame(8'h01, 1'b0, 8'h00, 1'b0);
    frame(8'h00, 1'b0, 8'h00, 1'b0);
    frame(8'h01, 1'b0, 8'h00, 1'b0);

    sel = 2'd3; valid = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 256; w++) frame(8'(w), 1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
